// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Central hazard controller for a 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB).
// Produces the stall, bubble and flush controls for the pipeline registers and
// the EX-stage operand forwarding selects. It also sequences data-memory wait
// states, runs a timeout watchdog on them, and keeps hazard performance
// counters.
//
// Parameters
//   MEM_TIMEOUT  consecutive stalled memory cycles before mem_timeout sets (2..65535)
//   CNT_W        width of the performance counters
//
// Ports
//   clk, rst                  clock; synchronous active-low reset
//   id_rs1_addr/id_rs2_addr   source registers of the ID instruction
//   id_rs1_used/id_rs2_used   ID instruction actually reads rs1 / rs2
//   ex_rs1_addr/ex_rs2_addr   source registers of the EX instruction
//   ex_rd_addr                destination of the EX instruction
//   ex_writeback_en           EX instruction writes back
//   ex_writeback_from_mem     EX instruction is a load
//   mem_rd_addr, mem_writeback_en, mem_writeback_from_mem   EX/MEM register output
//   wb_rd_addr, wb_writeback_en                             MEM/WB register output
//   branch_taken              EX resolved a taken branch / jump
//   dmem_req, dmem_ready      MEM-stage access active / access completes this cycle
//   stall_if..stall_mem       hold PC, IF/ID, ID/EX, EX/MEM
//   bubble_ex, bubble_wb      insert a NOP into ID/EX, MEM/WB
//   flush_if_id, flush_id_ex  clear IF/ID, ID/EX
//   fwd_a, fwd_b              EX operand source: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   mem_timeout               sticky watchdog error
//   stall_cycles, flush_count, load_use_count   performance counters
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rs1_addr,
    input  logic [4:0]       ex_rs2_addr,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_writeback_en,
    input  logic             ex_writeback_from_mem,
    input  logic [4:0]       mem_rd_addr,
    input  logic             mem_writeback_en,
    input  logic             mem_writeback_from_mem,
    input  logic [4:0]       wb_rd_addr,
    input  logic             wb_writeback_en,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             bubble_ex,
    output logic             bubble_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] load_use_count
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [15:0]      TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state;
    logic [15:0] wait_cnt;
    logic        load_use;
    logic        hold_mem;
    logic        lu_fire;
    logic        any_stall;

    // Saturating increment for the wait-state counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Operand source select. EX/MEM wins over MEM/WB; a load still in EX/MEM has
    // no data yet, so it cannot forward from there. x0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       m_we,
        input logic       m_ld,
        input logic [4:0] m_rd,
        input logic       w_we,
        input logic [4:0] w_rd
    );
        if (m_we && !m_ld && (m_rd != 5'd0) && (m_rd == rs))
            return 2'b01;
        else if (w_we && (w_rd != 5'd0) && (w_rd == rs))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign load_use = ex_writeback_en && ex_writeback_from_mem && (ex_rd_addr != 5'd0) &&
                      ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                       (id_rs2_used && (id_rs2_addr == ex_rd_addr)));

    // In RUN a stall starts only for an outstanding request; once waiting, the
    // wait ends on dmem_ready alone.
    assign hold_mem = (state == RUN) ? (dmem_req && !dmem_ready) : !dmem_ready;

    always_comb begin
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        stall_mem   = 1'b0;
        bubble_ex   = 1'b0;
        bubble_wb   = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        lu_fire     = 1'b0;
        if (!rst) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (hold_mem) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
            bubble_wb = 1'b1;
        end else if (branch_taken) begin
            // The ID instruction is discarded, so a load-use hazard on it is moot.
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (load_use) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
            lu_fire   = 1'b1;
        end
    end

    assign fwd_a = rst ? fwd_sel(ex_rs1_addr, mem_writeback_en, mem_writeback_from_mem,
                                 mem_rd_addr, wb_writeback_en, wb_rd_addr) : 2'b00;
    assign fwd_b = rst ? fwd_sel(ex_rs2_addr, mem_writeback_en, mem_writeback_from_mem,
                                 mem_rd_addr, wb_writeback_en, wb_rd_addr) : 2'b00;

    assign any_stall = stall_if || stall_id || stall_ex || stall_mem;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= RUN;
            wait_cnt       <= 16'd0;
            mem_timeout    <= 1'b0;
            stall_cycles   <= '0;
            flush_count    <= '0;
            load_use_count <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (dmem_req && !dmem_ready) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 16'd1;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state    <= RUN;
                        wait_cnt <= 16'd0;
                    end else begin
                        wait_cnt <= sat_inc16(wait_cnt);
                        // wait_cnt counts stalled cycles before this one, so the
                        // flag sets on the MEM_TIMEOUT-th stalled cycle.
                        if (wait_cnt == TIMEOUT_LAST)
                            mem_timeout <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase

            if (any_stall)
                stall_cycles <= stall_cycles + CNT_ONE;
            if (flush_if_id)
                flush_count <= flush_count + CNT_ONE;
            if (lu_fire)
                load_use_count <= load_use_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Self-checking bench for hazard_ctrl (MEM_TIMEOUT=4). Each cycle the expected
// control vector is queued when the inputs are driven and compared when the
// combinational outputs are sampled on the falling edge. Registered counters
// and the watchdog flag are checked 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 32;

    // {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_wb, flush_if_id, flush_id_ex}
    localparam logic [7:0] C_NONE  = 8'b0000_0000;
    localparam logic [7:0] C_MEM   = 8'b1111_0100;
    localparam logic [7:0] C_LU    = 8'b1100_1000;
    localparam logic [7:0] C_FLUSH = 8'b0000_0011;

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs1_addr, id_rs2_addr;
    logic             id_rs1_used, id_rs2_used;
    logic [4:0]       ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    logic             ex_writeback_en, ex_writeback_from_mem;
    logic [4:0]       mem_rd_addr;
    logic             mem_writeback_en, mem_writeback_from_mem;
    logic [4:0]       wb_rd_addr;
    logic             wb_writeback_en;
    logic             branch_taken, dmem_req, dmem_ready;
    logic             stall_if, stall_id, stall_ex, stall_mem;
    logic             bubble_ex, bubble_wb, flush_if_id, flush_id_ex;
    logic [1:0]       fwd_a, fwd_b;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_count, load_use_count;

    logic [7:0] ctrl_vec;
    assign ctrl_vec = {stall_if, stall_id, stall_ex, stall_mem,
                       bubble_ex, bubble_wb, flush_if_id, flush_id_ex};

    hazard_ctrl #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .id_rs1_addr           (id_rs1_addr),
        .id_rs2_addr           (id_rs2_addr),
        .id_rs1_used           (id_rs1_used),
        .id_rs2_used           (id_rs2_used),
        .ex_rs1_addr           (ex_rs1_addr),
        .ex_rs2_addr           (ex_rs2_addr),
        .ex_rd_addr            (ex_rd_addr),
        .ex_writeback_en       (ex_writeback_en),
        .ex_writeback_from_mem (ex_writeback_from_mem),
        .mem_rd_addr           (mem_rd_addr),
        .mem_writeback_en      (mem_writeback_en),
        .mem_writeback_from_mem(mem_writeback_from_mem),
        .wb_rd_addr            (wb_rd_addr),
        .wb_writeback_en       (wb_writeback_en),
        .branch_taken          (branch_taken),
        .dmem_req              (dmem_req),
        .dmem_ready            (dmem_ready),
        .stall_if              (stall_if),
        .stall_id              (stall_id),
        .stall_ex              (stall_ex),
        .stall_mem             (stall_mem),
        .bubble_ex             (bubble_ex),
        .bubble_wb             (bubble_wb),
        .flush_if_id           (flush_if_id),
        .flush_id_ex           (flush_id_ex),
        .fwd_a                 (fwd_a),
        .fwd_b                 (fwd_b),
        .mem_timeout           (mem_timeout),
        .stall_cycles          (stall_cycles),
        .flush_count           (flush_count),
        .load_use_count        (load_use_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] ctrl;
        logic [3:0] fwd;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Queue the expectation for the inputs currently driven, compare on the
    // falling edge, then advance to just after the next rising edge.
    task automatic step(input string tag, input logic [7:0] ctrl, input logic [3:0] fwd);
        exp_t e;
        e.tag  = tag;
        e.ctrl = ctrl;
        e.fwd  = fwd;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk(e.tag, {52'd0, ctrl_vec, fwd_a, fwd_b}, {52'd0, e.ctrl, e.fwd});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag, input int s, input int f, input int l, input logic t);
        chk({tag, ".stall_cycles"},   64'(stall_cycles),   64'(s));
        chk({tag, ".flush_count"},    64'(flush_count),    64'(f));
        chk({tag, ".load_use_count"}, 64'(load_use_count), 64'(l));
        chk({tag, ".mem_timeout"},    64'(mem_timeout),    64'(t));
    endtask

    task automatic clear_inputs();
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_rs1_addr = 5'd0; ex_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
        ex_writeback_en = 1'b0; ex_writeback_from_mem = 1'b0;
        mem_rd_addr = 5'd0; mem_writeback_en = 1'b0; mem_writeback_from_mem = 1'b0;
        wb_rd_addr = 5'd0; wb_writeback_en = 1'b0;
        branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        step(tag, C_FLUSH, 4'b0000);
        rst = 1'b1;
        clear_inputs();
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        ex_writeback_en       = 1'b1;
        ex_writeback_from_mem = 1'b1;
        ex_rd_addr            = rd;
        id_rs1_addr           = 5'd5;
        id_rs1_used           = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        clear_inputs();
        rst = 1'b0;

        // Reset with forwarding-worthy inputs: outputs must be forced.
        mem_writeback_en = 1'b1; mem_rd_addr = 5'd3; ex_rs1_addr = 5'd3; ex_rs2_addr = 5'd3;
        step("reset_forced", C_FLUSH, 4'b0000);
        rst = 1'b1;
        clear_inputs();
        check_regs("after_reset", 0, 0, 0, 1'b0);
        step("idle", C_NONE, 4'b0000);

        // Forwarding
        mem_writeback_en = 1'b1; mem_rd_addr = 5'd3;
        wb_writeback_en  = 1'b1; wb_rd_addr  = 5'd3;
        ex_rs1_addr = 5'd3; ex_rs2_addr = 5'd3;
        step("fwd_exmem", C_NONE, 4'b0101);
        mem_writeback_en = 1'b0;
        step("fwd_memwb", C_NONE, 4'b1010);
        mem_writeback_en = 1'b1; mem_writeback_from_mem = 1'b1;
        step("fwd_load_in_mem", C_NONE, 4'b1010);
        mem_writeback_from_mem = 1'b0; mem_rd_addr = 5'd0;
        ex_rs1_addr = 5'd0; ex_rs2_addr = 5'd0; wb_rd_addr = 5'd0;
        step("fwd_x0", C_NONE, 4'b0000);
        mem_rd_addr = 5'd3; wb_rd_addr = 5'd7; ex_rs1_addr = 5'd3; ex_rs2_addr = 5'd7;
        step("fwd_split", C_NONE, 4'b0110);
        clear_inputs();

        // Load-use
        do_reset("reset_lu");
        set_load_use(5'd5);
        step("lu_rs1", C_LU, 4'b0000);
        clear_inputs();
        check_regs("lu_once", 1, 0, 1, 1'b0);
        step("lu_release", C_NONE, 4'b0000);
        set_load_use(5'd0);
        id_rs1_addr = 5'd0;
        step("lu_rd_x0", C_NONE, 4'b0000);
        set_load_use(5'd9);
        id_rs1_used = 1'b0; id_rs2_addr = 5'd9; id_rs2_used = 1'b1;
        step("lu_rs2", C_LU, 4'b0000);
        id_rs2_used = 1'b0;
        step("lu_rs2_unused", C_NONE, 4'b0000);
        clear_inputs();
        check_regs("lu_total", 2, 0, 2, 1'b0);

        // Branch with a simultaneous load-use
        do_reset("reset_br");
        set_load_use(5'd5);
        branch_taken = 1'b1;
        step("br_over_lu", C_FLUSH, 4'b0000);
        clear_inputs();
        step("br_release", C_NONE, 4'b0000);
        check_regs("br", 0, 1, 0, 1'b0);

        // Memory wait: ready low 3 cycles then high
        do_reset("reset_mw");
        dmem_req = 1'b1;
        for (int i = 0; i < 3; i++) step("mw_stall", C_MEM, 4'b0000);
        check_regs("mw_wait", 3, 0, 0, 1'b0);
        dmem_ready = 1'b1;
        step("mw_complete", C_NONE, 4'b0000);
        clear_inputs();
        step("mw_run", C_NONE, 4'b0000);
        check_regs("mw_done", 3, 0, 0, 1'b0);

        // Timeout watchdog
        do_reset("reset_to");
        dmem_req = 1'b1;
        for (int i = 0; i < 3; i++) step("to_stall", C_MEM, 4'b0000);
        chk("to_not_yet", 64'(mem_timeout), 64'd0);
        step("to_stall4", C_MEM, 4'b0000);
        chk("to_set", 64'(mem_timeout), 64'd1);
        dmem_ready = 1'b1;
        step("to_complete", C_NONE, 4'b0000);
        check_regs("to_sticky", 4, 0, 0, 1'b1);
        dmem_ready = 1'b0;
        step("to_rewait", C_MEM, 4'b0000);
        rst = 1'b0;
        step("to_reset_in_wait", C_FLUSH, 4'b0000);
        rst = 1'b1;
        clear_inputs();
        check_regs("to_cleared", 0, 0, 0, 1'b0);
        step("to_back_in_run", C_NONE, 4'b0000);

        // Branch held during a 2-cycle wait, then load-use on a completion cycle
        do_reset("reset_bw");
        dmem_req = 1'b1; branch_taken = 1'b1;
        step("bw_stall1", C_MEM, 4'b0000);
        step("bw_stall2", C_MEM, 4'b0000);
        dmem_ready = 1'b1;
        step("bw_complete_flush", C_FLUSH, 4'b0000);
        clear_inputs();
        step("bw_release", C_NONE, 4'b0000);
        check_regs("bw", 2, 1, 0, 1'b0);
        dmem_req = 1'b1;
        step("lw_stall", C_MEM, 4'b0000);
        dmem_ready = 1'b1;
        set_load_use(5'd5);
        step("lw_complete_lu", C_LU, 4'b0000);
        clear_inputs();
        step("lw_release", C_NONE, 4'b0000);
        check_regs("lw", 4, 1, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
